// File: rtl/snoop_dispatcher_pkg.sv
// Shared types for the snoop dispatcher: ACE snoop channel structs, the
// dispatch state encoding and the CR response merge helper.
package snoop_dispatcher_pkg;

  typedef logic [3:0] acsnoop_t;

  localparam acsnoop_t ACSNOOP_READ_ONCE       = 4'b0000;
  localparam acsnoop_t ACSNOOP_READ_SHARED     = 4'b0001;
  localparam acsnoop_t ACSNOOP_READ_UNIQUE     = 4'b0111;
  localparam acsnoop_t ACSNOOP_CLEAN_INVALID   = 4'b1001;
  localparam acsnoop_t ACSNOOP_MAKE_INVALID    = 4'b1101;

  // Field order follows the ACE CRRESP bit order, MSB first.
  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } crresp_t;

  typedef struct packed {
    logic [63:0] addr;
    acsnoop_t    snoop;
  } ac_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    crresp_t  cr_resp;
    logic     cd_valid;
    cd_chan_t cd;
  } snoop_resp_t;

  typedef logic [2:0] dispatch_state_t;

  localparam dispatch_state_t ST_IDLE    = 3'd0;
  localparam dispatch_state_t ST_SEND_AC = 3'd1;
  localparam dispatch_state_t ST_WAIT_CR = 3'd2;
  localparam dispatch_state_t ST_RESP    = 3'd3;
  localparam dispatch_state_t ST_DATA    = 3'd4;

  // The merged response never claims unique ownership on behalf of a cache.
  function automatic crresp_t merge_crresp(crresp_t acc, crresp_t nxt);
    crresp_t r;
    r = acc | nxt;
    r.was_unique = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/snoop_dispatcher_if.sv
// Request/response/data bundle between the interconnect, the dispatcher and
// the per-core snoop ports.
interface snoop_dispatcher_if #(
  parameter int unsigned NoPorts = 2
) ();
  import snoop_dispatcher_pkg::*;

  // Every channel is valid/ready: a transfer happens on a rising clock edge
  // where both are high, and a raised valid holds its payload until then.
  logic                       ac_valid_i;
  logic                       ac_ready_o;
  logic [63:0]                ac_addr_i;
  acsnoop_t                   ac_snoop_i;
  logic [NoPorts-1:0]         ac_mask_i;
  snoop_req_t [NoPorts-1:0]   snoop_req_o;
  snoop_resp_t [NoPorts-1:0]  snoop_resp_i;
  logic                       resp_valid_o;
  logic                       resp_ready_i;
  crresp_t                    resp_o;
  logic                       data_valid_o;
  logic                       data_ready_i;
  logic [63:0]                data_o;
  logic                       data_last_o;
  dispatch_state_t            dbg_state_o;

  modport slave (
    input  ac_valid_i, ac_addr_i, ac_snoop_i, ac_mask_i, snoop_resp_i,
    input  resp_ready_i, data_ready_i,
    output ac_ready_o, snoop_req_o, resp_valid_o, resp_o,
    output data_valid_o, data_o, data_last_o, dbg_state_o
  );

  modport master (
    output ac_valid_i, ac_addr_i, ac_snoop_i, ac_mask_i, snoop_resp_i,
    output resp_ready_i, data_ready_i,
    input  ac_ready_o, snoop_req_o, resp_valid_o, resp_o,
    input  data_valid_o, data_o, data_last_o, dbg_state_o
  );

endinterface

// File: rtl/snoop_dispatcher.sv
// Broadcasts one snoop to a subset of cache ports, merges their CR responses,
// forwards the line from the lowest-index data responder and drains the rest.
module snoop_dispatcher
  import snoop_dispatcher_pkg::*;
#(
  parameter int unsigned NoPorts      = 2,
  parameter int unsigned BeatsPerLine = 2
) (
  input logic              clk_i,
  input logic              rst_ni,
  snoop_dispatcher_if.slave bus
);

  localparam int unsigned BeatW = (BeatsPerLine > 1) ? $clog2(BeatsPerLine) : 1;
  localparam int unsigned SelW  = (NoPorts > 1) ? $clog2(NoPorts) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BeatsPerLine - 1);

  dispatch_state_t    state_q, state_d;
  logic [63:0]        addr_q, addr_d;
  acsnoop_t           snoop_q, snoop_d;
  logic [NoPorts-1:0] mask_q, mask_d;
  logic [NoPorts-1:0] ac_done_q, ac_done_d;
  logic [NoPorts-1:0] cr_done_q, cr_done_d;
  logic [NoPorts-1:0] xfer_q, xfer_d;
  crresp_t            resp_q, resp_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [SelW-1:0]    sel_q, sel_d;
  logic [SelW-1:0]    sel_low;
  logic               fwd_last;

  assign bus.dbg_state_o = state_q;
  assign fwd_last        = (beat_q == LastBeat);

  // Priority pick of the lowest-index port that announced a data transfer.
  always_comb begin
    sel_low = '0;
    for (int i = int'(NoPorts) - 1; i >= 0; i--) begin
      if (xfer_q[i]) sel_low = SelW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    snoop_d   = snoop_q;
    mask_d    = mask_q;
    ac_done_d = ac_done_q;
    cr_done_d = cr_done_q;
    xfer_d    = xfer_q;
    resp_d    = resp_q;
    beat_d    = beat_q;
    sel_d     = sel_q;

    bus.ac_ready_o   = 1'b0;
    bus.snoop_req_o  = '0;
    bus.resp_valid_o = 1'b0;
    bus.resp_o       = '0;
    bus.data_valid_o = 1'b0;
    bus.data_o       = '0;
    bus.data_last_o  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus.ac_ready_o = 1'b1;
        if (bus.ac_valid_i) begin
          addr_d    = bus.ac_addr_i;
          snoop_d   = bus.ac_snoop_i;
          mask_d    = bus.ac_mask_i;
          ac_done_d = '0;
          cr_done_d = '0;
          xfer_d    = '0;
          resp_d    = '0;
          beat_d    = '0;
          state_d   = (bus.ac_mask_i != '0) ? ST_SEND_AC : ST_RESP;
        end
      end

      ST_SEND_AC: begin
        for (int i = 0; i < int'(NoPorts); i++) begin
          if (mask_q[i] && !ac_done_q[i]) begin
            bus.snoop_req_o[i].ac_valid   = 1'b1;
            bus.snoop_req_o[i].ac.addr    = addr_q;
            bus.snoop_req_o[i].ac.snoop   = snoop_q;
            if (bus.snoop_resp_i[i].ac_ready) ac_done_d[i] = 1'b1;
          end
        end
        if ((ac_done_d & mask_q) == mask_q) state_d = ST_WAIT_CR;
      end

      ST_WAIT_CR: begin
        // Several ports may respond in the same cycle; all are folded in.
        for (int i = 0; i < int'(NoPorts); i++) begin
          if (mask_q[i] && !cr_done_q[i]) begin
            bus.snoop_req_o[i].cr_ready = 1'b1;
            if (bus.snoop_resp_i[i].cr_valid) begin
              cr_done_d[i] = 1'b1;
              resp_d       = merge_crresp(resp_d, bus.snoop_resp_i[i].cr_resp);
              if (bus.snoop_resp_i[i].cr_resp.data_transfer) xfer_d[i] = 1'b1;
            end
          end
        end
        if ((cr_done_d & mask_q) == mask_q) state_d = ST_RESP;
      end

      ST_RESP: begin
        bus.resp_valid_o = 1'b1;
        bus.resp_o       = resp_q;
        if (bus.resp_ready_i) begin
          sel_d   = sel_low;
          state_d = (xfer_q == '0) ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        // sel_q stays fixed so a drained port never becomes the forwarded one.
        if (xfer_q[sel_q]) begin
          bus.data_valid_o = bus.snoop_resp_i[sel_q].cd_valid;
          bus.data_o       = bus.snoop_resp_i[sel_q].cd.data;
          bus.data_last_o  = fwd_last;
        end
        for (int i = 0; i < int'(NoPorts); i++) begin
          if (xfer_q[i]) begin
            if (SelW'(i) == sel_q) begin
              bus.snoop_req_o[i].cd_ready = bus.data_ready_i;
              if (bus.snoop_resp_i[i].cd_valid && bus.data_ready_i) begin
                beat_d = fwd_last ? '0 : beat_q + 1'b1;
                if (fwd_last) xfer_d[i] = 1'b0;
              end
            end else begin
              bus.snoop_req_o[i].cd_ready = 1'b1;
              if (bus.snoop_resp_i[i].cd_valid && bus.snoop_resp_i[i].cd.last) xfer_d[i] = 1'b0;
            end
          end
        end
        if (xfer_d == '0) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      snoop_q   <= '0;
      mask_q    <= '0;
      ac_done_q <= '0;
      cr_done_q <= '0;
      xfer_q    <= '0;
      resp_q    <= '0;
      beat_q    <= '0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      snoop_q   <= snoop_d;
      mask_q    <= mask_d;
      ac_done_q <= ac_done_d;
      cr_done_q <= cr_done_d;
      xfer_q    <= xfer_d;
      resp_q    <= resp_d;
      beat_q    <= beat_d;
      sel_q     <= sel_d;
    end
  end

  a_fwd_last_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.data_valid_o && bus.data_ready_i) |-> (bus.snoop_resp_i[sel_q].cd.last == bus.data_last_o));

endmodule

// File: tb/tb_snoop_dispatcher.sv
// Bench for snoop_dispatcher: models each cache port and the upstream side
// cycle by cycle and compares against a line/response reference model.
module tb_snoop_dispatcher;
  import snoop_dispatcher_pkg::*;

  localparam int NP      = 2;
  localparam int BPL     = 2;
  localparam int TIMEOUT = 200;

  logic clk;
  logic rst_n;

  snoop_dispatcher_if #(.NoPorts(NP)) bus ();

  snoop_dispatcher #(.NoPorts(NP), .BeatsPerLine(BPL)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt;
  int err_cnt;

  // Cache-side and transaction model state.
  logic [NP-1:0] m_mask;
  logic [63:0]   m_addr;
  acsnoop_t      m_snoop;
  int            ac_wait[NP];
  int            ac_got[NP];
  int            cr_wait[NP];
  int            cr_got[NP];
  int            cd_idx[NP];
  int            cd_gap[NP];
  crresp_t       cr_val[NP];
  logic [63:0]   line[NP][BPL];
  int            m_fwd;
  crresp_t       m_exp_resp;
  int            resp_cnt;
  int            violations;
  bit            abort_req;
  int            rdy_mode;
  logic [64:0]   exp_q[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.ac_valid_i   = 1'b0;
    bus.ac_addr_i    = '0;
    bus.ac_snoop_i   = '0;
    bus.ac_mask_i    = '0;
    bus.snoop_resp_i = '0;
    bus.resp_ready_i = 1'b0;
    bus.data_ready_i = 1'b0;
  endtask

  task automatic clear_model();
    m_mask  = '0;
    m_addr  = '0;
    m_snoop = '0;
    for (int p = 0; p < NP; p++) begin
      ac_wait[p] = 0; ac_got[p] = 0; cr_wait[p] = 0; cr_got[p] = 0;
      cd_idx[p]  = 0; cd_gap[p] = 0; cr_val[p] = '0;
      for (int b = 0; b < BPL; b++) line[p][b] = '0;
    end
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      snoop_resp_t rs;
      rs          = '0;
      rs.ac_ready = (ac_wait[p] == 0);
      rs.cr_valid = m_mask[p] && ac_got[p] > 0 && cr_got[p] == 0 && cr_wait[p] == 0;
      rs.cr_resp  = cr_val[p];
      if (cr_got[p] > 0 && cr_val[p].data_transfer && cd_idx[p] < BPL) begin
        rs.cd_valid = (cd_gap[p] == 0);
        rs.cd.data  = line[p][cd_idx[p]];
        rs.cd.last  = (cd_idx[p] == BPL - 1);
      end
      bus.snoop_resp_i[p] = rs;
    end
    case (rdy_mode)
      0:       bus.data_ready_i = ($urandom_range(0, 1) == 1);
      1:       bus.data_ready_i = ~bus.data_ready_i;
      default: bus.data_ready_i = 1'b1;
    endcase
    bus.resp_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic observe(input bit abort);
    bit          all_ac;
    bit          all_cr;
    snoop_req_t  rq;
    snoop_resp_t rs;
    logic [64:0] exp;
    all_ac = 1'b1;
    all_cr = 1'b1;
    for (int p = 0; p < NP; p++) begin
      if (m_mask[p] && ac_got[p] == 0) all_ac = 1'b0;
      if (m_mask[p] && cr_got[p] == 0) all_cr = 1'b0;
    end
    for (int p = 0; p < NP; p++) begin
      rq = bus.snoop_req_o[p];
      rs = bus.snoop_resp_i[p];
      if (!m_mask[p] && (rq.ac_valid || rq.cr_ready || rq.cd_ready)) violations++;
      if (rq.ac_valid && ac_got[p] > 0) violations++;
      if (rq.cr_ready && (!all_ac || cr_got[p] > 0)) violations++;
      if (rq.cd_ready && (resp_cnt == 0 || !cr_val[p].data_transfer)) violations++;
      if (rq.ac_valid && rs.ac_ready) begin
        check_eq("ac_addr", rq.ac.addr, m_addr);
        check_eq("ac_snoop", rq.ac.snoop, m_snoop);
        ac_got[p]++;
      end
      if (rs.cr_valid && rq.cr_ready) cr_got[p]++;
      if (rs.cd_valid && rq.cd_ready) begin
        if (p == m_fwd && !(bus.data_valid_o && bus.data_ready_i)) violations++;
        cd_idx[p]++;
        cd_gap[p] = $urandom_range(0, 1);
      end else if (!rs.cd_valid && cd_gap[p] > 0) begin
        cd_gap[p]--;
      end
      if (ac_wait[p] > 0) ac_wait[p]--;
      if (ac_got[p] > 0 && cr_wait[p] > 0) cr_wait[p]--;
    end
    if (bus.data_valid_o && resp_cnt == 0) violations++;
    if (bus.data_valid_o && bus.data_ready_i) begin
      if (exp_q.size() == 0) begin
        check_eq("data_unexpected", 1, 0);
      end else begin
        exp = exp_q.pop_front();
        check_eq("data_beat", {bus.data_last_o, bus.data_o}, exp);
      end
      if (abort) abort_req = 1'b1;
    end
    if (bus.resp_valid_o && bus.resp_ready_i) begin
      check_eq("resp", bus.resp_o, m_exp_resp);
      if (!all_cr) violations++;
      resp_cnt++;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one snoop with the model state already loaded into m_* / cr_val / line.
  task automatic run_txn(input bit abort);
    bit done;
    m_exp_resp = '0;
    m_fwd      = -1;
    exp_q.delete();
    for (int p = 0; p < NP; p++) begin
      if (m_mask[p]) begin
        m_exp_resp.is_shared     = m_exp_resp.is_shared     | cr_val[p].is_shared;
        m_exp_resp.pass_dirty    = m_exp_resp.pass_dirty    | cr_val[p].pass_dirty;
        m_exp_resp.error         = m_exp_resp.error         | cr_val[p].error;
        m_exp_resp.data_transfer = m_exp_resp.data_transfer | cr_val[p].data_transfer;
        if (cr_val[p].data_transfer && m_fwd < 0) m_fwd = p;
      end
      ac_got[p] = 0; cr_got[p] = 0; cd_idx[p] = 0; cd_gap[p] = 0;
    end
    if (m_fwd >= 0) begin
      for (int b = 0; b < BPL; b++) exp_q.push_back({(b == BPL - 1), line[m_fwd][b]});
    end
    resp_cnt   = 0;
    violations = 0;
    abort_req  = 1'b0;

    @(negedge clk);
    drive_inputs();
    bus.ac_valid_i = 1'b1;
    bus.ac_addr_i  = m_addr;
    bus.ac_snoop_i = m_snoop;
    bus.ac_mask_i  = m_mask;
    #1;
    check_eq("ac_ready_idle", bus.ac_ready_o, 1);
    @(negedge clk);
    bus.ac_valid_i = 1'b0;
    bus.ac_mask_i  = '0;

    done = 1'b0;
    for (int cyc = 0; cyc < TIMEOUT && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (abort_req) begin
        #2;
        rst_n = 1'b0;
        #1;
        for (int p = 0; p < NP; p++) check_eq("rst_snoop_req", bus.snoop_req_o[p], '0);
        check_eq("rst_resp_valid", bus.resp_valid_o, 0);
        check_eq("rst_data_valid", bus.data_valid_o, 0);
        check_eq("rst_state", bus.dbg_state_o, ST_IDLE);
        clear_inputs();
        clear_model();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_ac_ready", bus.ac_ready_o, 1);
        return;
      end
      drive_inputs();
      #1;
      if (resp_cnt > 0 && bus.ac_ready_o) done = 1'b1;
      else observe(abort);
    end

    if (!done) begin
      check_eq("timeout", 1, 0);
      pulse_reset();
      return;
    end
    for (int p = 0; p < NP; p++) begin
      check_eq("ac_count", ac_got[p], m_mask[p] ? 1 : 0);
      check_eq("cr_count", cr_got[p], m_mask[p] ? 1 : 0);
      check_eq("cd_count", cd_idx[p], (m_mask[p] && cr_val[p].data_transfer) ? BPL : 0);
    end
    check_eq("fwd_remaining", exp_q.size(), 0);
    check_eq("resp_count", resp_cnt, 1);
    check_eq("protocol", violations, 0);
    check_eq("idle_state", bus.dbg_state_o, ST_IDLE);
    check_eq("idle_resp_valid", bus.resp_valid_o, 0);
  endtask

  task automatic load_lines(input logic [63:0] base);
    for (int p = 0; p < NP; p++)
      for (int b = 0; b < BPL; b++) line[p][b] = base + 64'(p * 16 + b);
  endtask

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    rdy_mode  = 2;
    abort_req = 1'b0;
    rst_n     = 1'b0;
    clear_inputs();
    clear_model();
    repeat (3) @(negedge clk);
    #1;
    for (int p = 0; p < NP; p++) check_eq("reset_snoop_req", bus.snoop_req_o[p], '0);
    check_eq("reset_resp_valid", bus.resp_valid_o, 0);
    check_eq("reset_data_valid", bus.data_valid_o, 0);
    check_eq("reset_ac_ready", bus.ac_ready_o, 1);
    rst_n = 1'b1;

    // Empty mask: immediate zero response.
    clear_model();
    m_addr = 64'h8000_0040; m_snoop = ACSNOOP_READ_SHARED; m_mask = 2'b00;
    run_txn(1'b0);

    // Both miss, port 0 accepts AC three cycles after port 1.
    clear_model();
    m_addr = 64'h8000_0080; m_snoop = ACSNOOP_READ_SHARED; m_mask = 2'b11;
    ac_wait[0] = 3; ac_wait[1] = 0;
    run_txn(1'b0);

    // Port 1 supplies a shared line, port 0 misses.
    clear_model();
    m_addr = 64'h8000_00C0; m_snoop = ACSNOOP_READ_SHARED; m_mask = 2'b11;
    cr_val[1].data_transfer = 1'b1; cr_val[1].is_shared = 1'b1;
    line[1][0] = 64'hAAAA_AAAA_AAAA_AAAA; line[1][1] = 64'hBBBB_BBBB_BBBB_BBBB;
    run_txn(1'b0);

    // Both transfer, port 0 dirty and forwarded under a toggling ready.
    clear_model();
    m_addr = 64'h8000_0100; m_snoop = ACSNOOP_READ_UNIQUE; m_mask = 2'b11;
    cr_val[0].data_transfer = 1'b1; cr_val[0].pass_dirty = 1'b1;
    cr_val[1].data_transfer = 1'b1;
    load_lines(64'h1234_0000_0000_0000);
    rdy_mode = 1;
    run_txn(1'b0);
    rdy_mode = 2;

    // Simultaneous CR from both ports, port 1 reports an error.
    clear_model();
    m_addr = 64'h8000_0140; m_snoop = ACSNOOP_CLEAN_INVALID; m_mask = 2'b11;
    cr_wait[0] = 2; cr_wait[1] = 2;
    cr_val[1].error = 1'b1; cr_val[0].was_unique = 1'b1;
    run_txn(1'b0);

    // Reset after the first forwarded beat, then a clean repeat.
    for (int k = 0; k < 2; k++) begin
      clear_model();
      m_addr = 64'h8000_0180; m_snoop = ACSNOOP_READ_SHARED; m_mask = 2'b11;
      cr_val[0].data_transfer = 1'b1; cr_val[1].data_transfer = 1'b1;
      load_lines(64'hCAFE_0000_0000_0000 + 64'(k));
      run_txn(k == 0);
    end

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      clear_model();
      m_addr  = {$urandom, $urandom} & ~64'h3F;
      m_snoop = acsnoop_t'($urandom_range(0, 15));
      m_mask  = NP'($urandom_range(0, (1 << NP) - 1));
      for (int p = 0; p < NP; p++) begin
        ac_wait[p] = $urandom_range(0, 4);
        cr_wait[p] = $urandom_range(0, 4);
        cr_val[p]  = crresp_t'($urandom_range(0, 31));
        cr_val[p].error = ($urandom_range(0, 3) == 0);
        for (int b = 0; b < BPL; b++) line[p][b] = {$urandom, $urandom};
      end
      rdy_mode = $urandom_range(0, 2);
      run_txn(1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/snoop_dispatcher.md
Name: snoop_dispatcher

Overview:
- Sits upstream of each core's snoop cache controller, on the coherency-interconnect side.
- Takes one snoop request, broadcasts it on the AC channel to a selectable subset of NoPorts cache snoop ports, and collects every CR response.
- Returns a single merged response, then forwards exactly one cache line from the lowest-index responder that transfers data.
- Drains (discards) CD data from every other responder.

Parameters:
NoPorts, 2, number of snooped cache ports (>=1)
BeatsPerLine, 2, CD beats per cache line (DCACHE_LINE_WIDTH/64)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
ac_valid_i  in  1  incoming snoop request valid
ac_ready_o  out  1  request accepted
ac_addr_i  in  64  snoop address
ac_snoop_i  in  $bits(snoop_pkg::acsnoop_t)  snoop type
ac_mask_i  in  NoPorts  ports to snoop (initiator excluded by caller)
snoop_req_o  out  NoPorts x ariane_ace::snoop_req_t  per-port ac_valid/ac/cr_ready/cd_ready
snoop_resp_i  in  NoPorts x ariane_ace::snoop_resp_t  per-port ac_ready/cr_valid/cr_resp/cd_valid/cd
resp_valid_o  out  1  merged response valid
resp_ready_i  in  1  merged response accepted
resp_o  out  $bits(snoop_pkg::crresp_t)  merged response
data_valid_o  out  1  forwarded line beat valid
data_ready_i  in  1  beat accepted
data_o  out  64  beat data
data_last_o  out  1  final beat

Behaviour:
- Reset (async, rst_ni low): state IDLE; all masks, done vectors, beat counter and merged response cleared. Outputs after reset: ac_ready_o=1; all snoop_req_o fields 0; resp_valid_o=0; data_valid_o=0.
- Reset mid-operation aborts the transaction with no further handshakes.
- IDLE:
  - ac_ready_o=1.
  - On ac_valid_i: latch addr, snoop and mask.
  - mask!=0 -> SEND_AC.
  - mask==0 -> RESP with resp_o=0 (resp_valid_o the cycle after accept).
- SEND_AC:
  - ac_valid=1 with ac.addr/ac.snoop to each masked port whose ac_done bit is clear.
  - A port's bit sets on ac_valid&&ac_ready.
  - Ports complete independently, in any order and any cycle.
  - All masked done -> WAIT_CR.
- WAIT_CR:
  - cr_ready=1 to each masked port whose cr_done bit is clear.
  - On cr_valid&&cr_ready, OR-accumulate dataTransfer, passDirty, isShared, error.
  - Record the port in xfer_mask if dataTransfer=1.
  - Simultaneous responses from several ports in one cycle are all captured.
  - All masked done -> RESP.
- RESP:
  - resp_valid_o=1, resp_o=merged response with wasUnique=0.
  - On resp_ready_i: xfer_mask==0 -> IDLE, else -> DATA.
  - sel = lowest set bit of xfer_mask.
- DATA:
  - Port sel: data_valid_o=cd_valid[sel], data_o=cd.data[sel], cd_ready[sel]=data_ready_i (combinational, zero latency).
  - data_last_o=1 when beat counter==BeatsPerLine-1.
  - Counter increments per forwarded handshake and wraps to 0 on last.
  - Every other port in xfer_mask: cd_ready=1 (drain) until its cd.last handshake, which clears its bit.
  - sel's bit clears on its last handshake.
  - xfer_mask==0 -> IDLE. ac_ready_o rises the next cycle.
- cd_ready is never asserted outside DATA; caches must hold CD until then.
- CR is always fully collected before any CD handshake.
- Assertion: forwarded cd.last must equal data_last_o.
- One transaction in flight; no new AC accepted until return to IDLE.
- Error responses are merged like other flags; an errored port with dataTransfer=1 is still forwarded or drained.

Decomposition:
- snoop_pkg gains dispatch_state_t (IDLE, SEND_AC, WAIT_CR, RESP, DATA).
- snoop_pkg gains a merge_crresp function (OR of flags, wasUnique cleared).
- Lowest-index data-port selection uses common_cells lzc; no new sub-module.

Test Plan:
- mask=0, READ_SHARED @0x8000_0040 -> ac_ready_o pulse, resp_valid_o next cycle with resp_o=0, no data, no snoop_req_o activity.
- mask=2'b11, port0 ac_ready 3 cycles after port1; both CR miss (all 0) -> merged resp 0, no DATA state, back to IDLE, ac_ready_o=1.
- mask=2'b11, port1 dataTransfer=1,isShared=1, data 0xAAAA.., 0xBBBB..; port0 miss -> resp isShared=1,dataTransfer=1; beats AAAA (last=0), BBBB (last=1).
- Both ports dataTransfer=1, port0 passDirty=1; data_ready_i toggles 1/0 -> port0 line forwarded with stalls honoured; port1 two beats drained; resp passDirty=1.
- Both CR valid in the same cycle, port1 error=1 -> single-cycle capture of both, resp error=1.
- rst_ni asserted during DATA after beat 0 -> all outputs 0 at once, ac_ready_o=1 after release; next request completes normally with beat counter starting at 0.
